pe_mp_v2: RTL
=============

Name: pe_mp_v2

Overview:
Second-generation systolic-array processing element supporting the weight-stationary (WS) and output-stationary (OS) dataflows. Compared with the first-generation PE it adds:
- independent data, weight and accumulator widths
- signed MAC with optional saturation
- a double-buffered (shadow/active) weight register
- per-path valid tags
- an explicit OS drain mode that shifts accumulated results down the column
It tiles into the LeNet accelerator's systolic array: horizontal data chain, vertical weight/psum/result chain.

Parameters:
DATA_WIDTH, 8, activation width (signed two's complement)
WEIGHT_WIDTH, 8, weight width (signed)
ACC_WIDTH, 20, partial-sum/accumulator width; must be >= DATA_WIDTH+WEIGHT_WIDTH
SATURATE, 1, 1: clamp adds to signed ACC range; 0: wrap modulo 2^ACC_WIDTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
mode  in  3  000 IDLE, 001 WS_LOAD, 011 WS_COMPUTE, 010 OS_COMPUTE, 100 OS_DRAIN; other codes = IDLE
weight_swap  in  1  pulse: copy shadow weight into active weight
acc_clr  in  1  clear accumulator and sat_flag
data_in  in  DATA_WIDTH  horizontal activation in
data_valid_in  in  1  qualifies data_in
weight_sum_in  in  ACC_WIDTH  vertical in; weight in low WEIGHT_WIDTH bits (WS_LOAD, OS_COMPUTE), psum or drained result otherwise
weight_sum_valid_in  in  1  qualifies weight_sum_in
data_out  out  DATA_WIDTH  registered horizontal forward
data_valid_out  out  1  registered data valid
weight_sum_out  out  ACC_WIDTH  registered vertical out
weight_sum_valid_out  out  1  registered vertical valid
acc_out  out  ACC_WIDTH  accumulator register, always driven (no tri-state)
sat_flag  out  1  sticky: a saturation occurred

Behaviour:
- Reset: all registers, and therefore all outputs, go to 0: active/shadow weight, acc, data_out, weight_sum_out, both valid_outs, sat_flag. rst asserted mid-operation aborts immediately; no partial state is retained.
- Every path has 1-cycle latency. Outputs are registered; no combinational in-to-out path.
- Arithmetic:
  - product = signed(data) * signed(weight), sign-extended to ACC_WIDTH.
  - Additions are signed.
  - With SATURATE=1, results clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] and sat_flag is set.
- Data chain (WS_COMPUTE, OS_COMPUTE): data_out<=data_in; data_valid_out<=data_valid_in. In all other modes data_out holds and data_valid_out<=0.
- WS_LOAD: when weight_sum_valid_in=1:
  - shadow<=weight_sum_in[WEIGHT_WIDTH-1:0]
  - weight_sum_out<=sign-extended old shadow
  - weight_sum_valid_out<=1
  - This forms a column shift chain. When weight_sum_valid_in=0, shadow holds and weight_sum_valid_out<=0.
- weight_swap: in any mode, active<=shadow at the clock edge. A MAC in the same cycle uses the old active weight.
- WS_COMPUTE:
  - weight_sum_out<=sat((psum_valid ? weight_sum_in : 0) + (data_valid ? product(data_in, active) : 0))
  - weight_sum_valid_out<=data_valid_in | weight_sum_valid_in
  - If neither input is valid, weight_sum_out holds.
- OS_COMPUTE:
  - When data_valid_in & weight_sum_valid_in: acc<=sat(acc + product(data_in, weight_sum_in[W-1:0])).
  - weight_sum_out<=weight_sum_in; weight_sum_valid_out<=weight_sum_valid_in (weight forwarded down).
  - acc_clr alone: acc<=0.
  - acc_clr together with a valid MAC: acc<=sat(0+product), i.e. clear-then-accumulate.
- OS_DRAIN: a previous-mode register detects drain entry.
  - First drain cycle: weight_sum_out<=acc, weight_sum_valid_out<=1, acc<=0.
  - Later drain cycles: weight_sum_out<=weight_sum_in, weight_sum_valid_out<=weight_sum_valid_in.
  - A column of N PEs emits N results over N cycles, bottom PE first.
- sat_flag is cleared by acc_clr or rst only. If acc_clr coincides with a saturating add, sat_flag<=1.
- IDLE and mode changes: acc, weights and data regs hold; both valid_outs<=0. acc persists across modes except on OS_DRAIN entry.

Test Plan:
1. Reset mid-op: acc=500 in OS_COMPUTE, pulse rst for 1 cycle -> all outputs 0 asynchronously, before the next edge; acc stays 0 afterwards.
2. WS_LOAD inputs 3 then 5, both valid -> weight_sum_out 0 then 3; shadow=5. Pulse swap, then WS_COMPUTE with data 4 (valid) and psum 10 (valid) -> weight_sum_out 30 next cycle, valid=1.
3. OS_COMPUTE with pairs (2,3), (-4,5), (7,-1) -> acc 6, -14, -21. Next pair (1,1) with acc_clr -> acc=1.
4. SATURATE=1, ACC_WIDTH=20: accumulate 127*127 repeatedly -> after 32 MACs acc=516128, sat_flag=0; 33rd MAC -> acc=524287, sat_flag=1. acc_clr -> sat_flag=0.
5. Drain: acc=-21, mode OS_DRAIN, weight_sum_in=77 valid -> cycle 1 weight_sum_out=-21 with valid=1 and acc=0; cycle 2 weight_sum_out=77.
6. Swap during WS_COMPUTE: active=2, shadow=9, data 10 every cycle with psum 0 valid, swap pulsed at cycle k -> outputs 20 through cycle k, 90 from cycle k+1. Invalid mode 111 -> valid_outs 0, all registers hold.

Source files
------------

// File: rtl/pe_mp_v2.sv
// rtl/pe_mp_v2.sv - weight/output-stationary systolic processing element with saturating signed MAC
module pe_mp_v2 #(
   parameter int DATA_WIDTH   = 8,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACC_WIDTH    = 20,
   parameter int SATURATE     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            mode,
   input  logic                  weight_swap,
   input  logic                  acc_clr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid_in,
   input  logic [ACC_WIDTH-1:0]  weight_sum_in,
   input  logic                  weight_sum_valid_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid_out,
   output logic [ACC_WIDTH-1:0]  weight_sum_out,
   output logic                  weight_sum_valid_out,
   output logic [ACC_WIDTH-1:0]  acc_out,
   output logic                  sat_flag
);

   localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;

   typedef enum logic [2:0] {
      M_IDLE       = 3'b000,
      M_WS_LOAD    = 3'b001,
      M_OS_COMPUTE = 3'b010,
      M_WS_COMPUTE = 3'b011,
      M_OS_DRAIN   = 3'b100
   } mode_t;

   mode_t cur_mode;
   mode_t prev_mode;

   logic signed [WEIGHT_WIDTH-1:0] active_w;
   logic signed [WEIGHT_WIDTH-1:0] shadow_w;
   logic signed [ACC_WIDTH-1:0]    acc;

   logic signed [PW-1:0] data_ext;
   logic signed [PW-1:0] active_ext;
   logic signed [PW-1:0] os_w_ext;
   logic signed [PW-1:0] ws_prod;
   logic signed [PW-1:0] os_prod;

   logic [ACC_WIDTH-1:0] ws_psum;
   logic [ACC_WIDTH-1:0] ws_term;
   logic [ACC_WIDTH-1:0] os_base;
   logic [ACC_WIDTH:0]   ws_res;
   logic [ACC_WIDTH:0]   os_res;

   logic ws_fire;
   logic os_fire;
   logic drain_first;
   logic sat_event;

   // Signed add with optional clamp; returns {saturated, result}
   function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                  input logic [ACC_WIDTH-1:0] b);
      logic [ACC_WIDTH:0] wide;
      logic               ovf;
      wide = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
      ovf  = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
      if (ovf && (SATURATE != 0)) begin
         return {1'b1, wide[ACC_WIDTH], {(ACC_WIDTH-1){~wide[ACC_WIDTH]}}};
      end
      return {1'b0, wide[ACC_WIDTH-1:0]};
   endfunction

   // Reserved mode codes behave as IDLE
   always_comb begin
      cur_mode = M_IDLE;
      case (mode)
         3'b001:  cur_mode = M_WS_LOAD;
         3'b010:  cur_mode = M_OS_COMPUTE;
         3'b011:  cur_mode = M_WS_COMPUTE;
         3'b100:  cur_mode = M_OS_DRAIN;
         default: cur_mode = M_IDLE;
      endcase
   end

   // Both products are formed at full precision then sign-extended into the accumulator width
   always_comb begin
      data_ext    = PW'($signed(data_in));
      active_ext  = PW'(active_w);
      os_w_ext    = PW'($signed(weight_sum_in[WEIGHT_WIDTH-1:0]));
      ws_prod     = data_ext * active_ext;
      os_prod     = data_ext * os_w_ext;
      ws_psum     = weight_sum_valid_in ? weight_sum_in : '0;
      ws_term     = data_valid_in ? ACC_WIDTH'(ws_prod) : '0;
      ws_res      = sat_add(ws_psum, ws_term);
      os_base     = acc_clr ? '0 : acc;
      os_res      = sat_add(os_base, ACC_WIDTH'(os_prod));
      ws_fire     = (cur_mode == M_WS_COMPUTE) && (data_valid_in || weight_sum_valid_in);
      os_fire     = (cur_mode == M_OS_COMPUTE) && data_valid_in && weight_sum_valid_in;
      drain_first = (cur_mode == M_OS_DRAIN) && (prev_mode != M_OS_DRAIN);
      sat_event   = (ws_fire && ws_res[ACC_WIDTH]) || (os_fire && os_res[ACC_WIDTH]);
   end

   // Horizontal activation chain, live only in the compute modes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out       <= '0;
         data_valid_out <= 1'b0;
      end else if (cur_mode == M_WS_COMPUTE || cur_mode == M_OS_COMPUTE) begin
         data_out       <= data_in;
         data_valid_out <= data_valid_in;
      end else begin
         data_valid_out <= 1'b0;
      end
   end

   // Shadow weight loads through the column chain; swap promotes it, a same-cycle MAC sees the old active
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_w <= '0;
         active_w <= '0;
      end else begin
         if (cur_mode == M_WS_LOAD && weight_sum_valid_in) begin
            shadow_w <= $signed(weight_sum_in[WEIGHT_WIDTH-1:0]);
         end
         if (weight_swap) begin
            active_w <= shadow_w;
         end
      end
   end

   // Vertical path, accumulator and sticky saturation, sequenced by mode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_mode            <= M_IDLE;
         weight_sum_out       <= '0;
         weight_sum_valid_out <= 1'b0;
         acc                  <= '0;
         sat_flag             <= 1'b0;
      end else begin
         prev_mode            <= cur_mode;
         weight_sum_valid_out <= 1'b0;
         if (acc_clr) begin
            acc <= '0;
         end
         case (cur_mode)
            M_WS_LOAD: begin
               if (weight_sum_valid_in) begin
                  weight_sum_out       <= ACC_WIDTH'(shadow_w);
                  weight_sum_valid_out <= 1'b1;
               end
            end
            M_WS_COMPUTE: begin
               if (ws_fire) begin
                  weight_sum_out       <= ws_res[ACC_WIDTH-1:0];
                  weight_sum_valid_out <= 1'b1;
               end
            end
            M_OS_COMPUTE: begin
               weight_sum_out       <= weight_sum_in;
               weight_sum_valid_out <= weight_sum_valid_in;
               if (os_fire) begin
                  acc <= os_res[ACC_WIDTH-1:0];
               end
            end
            M_OS_DRAIN: begin
               if (drain_first) begin
                  weight_sum_out       <= acc;
                  weight_sum_valid_out <= 1'b1;
                  acc                  <= '0;
               end else begin
                  weight_sum_out       <= weight_sum_in;
                  weight_sum_valid_out <= weight_sum_valid_in;
               end
            end
            default: begin
            end
         endcase
         sat_flag <= acc_clr ? sat_event : (sat_flag | sat_event);
      end
   end

   assign acc_out = acc;

endmodule
